// File: rtl/mw_pkg.sv
// rtl/mw_pkg.sv - shared types, key indices, 7-segment patterns and BCD helper for the microwave controller
package mw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        COOK,
        PAUSED,
        DONE,
        CONF_SEL,
        CONF_REC
    } state_t;

    // One resolved front-panel action per cycle, highest priority first.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CANCEL,
        ACT_START,
        ACT_CONF,
        ACT_RECIPE,
        ACT_DIGIT
    } action_t;

    localparam int KEY_START  = 10;
    localparam int KEY_CANCEL = 11;

    // gfedcba, active-high
    localparam logic [6:0] SEG7_0     = 7'b0111111;
    localparam logic [6:0] SEG7_1     = 7'b0000110;
    localparam logic [6:0] SEG7_2     = 7'b1011011;
    localparam logic [6:0] SEG7_3     = 7'b1001111;
    localparam logic [6:0] SEG7_4     = 7'b1100110;
    localparam logic [6:0] SEG7_5     = 7'b1101101;
    localparam logic [6:0] SEG7_6     = 7'b1111101;
    localparam logic [6:0] SEG7_7     = 7'b0000111;
    localparam logic [6:0] SEG7_8     = 7'b1111111;
    localparam logic [6:0] SEG7_9     = 7'b1101111;
    localparam logic [6:0] SEG7_BLANK = 7'b0000000;

    // Single BCD digit minus one; 0 wraps to 9 and the caller handles the borrow.
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - combinational BCD to gfedcba decoder, blank for non-BCD codes
module seg7_dec
    import mw_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Lookup of the display pattern for one digit.
    always_comb begin
        seg = SEG7_BLANK;
        case (bcd)
            4'd0:    seg = SEG7_0;
            4'd1:    seg = SEG7_1;
            4'd2:    seg = SEG7_2;
            4'd3:    seg = SEG7_3;
            4'd4:    seg = SEG7_4;
            4'd5:    seg = SEG7_5;
            4'd6:    seg = SEG7_6;
            4'd7:    seg = SEG7_7;
            4'd8:    seg = SEG7_8;
            4'd9:    seg = SEG7_9;
            default: seg = SEG7_BLANK;
        endcase
    end

endmodule

// File: rtl/microwave_ctrl_param.sv
// rtl/microwave_ctrl_param.sv - microwave controller: keypad entry, MM:SS countdown, recipes, beep
module microwave_ctrl_param
    import mw_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int NUM_RECIPES   = 4,
    parameter int TICKS_PER_SEC = 1000,
    parameter int BEEP_CYCLES   = 3000
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [11:0]            t,
    input  logic                   conf,
    input  logic [NUM_RECIPES-1:0] r,
    input  logic                   porta,
    output logic [7*DIGITS-1:0]    seg,
    output logic                   luz,
    output logic                   motor,
    output logic                   aquec,
    output logic                   som
);

    localparam int TMW = 4 * DIGITS;
    localparam int CW  = $clog2(DIGITS + 1);
    localparam int RW  = (NUM_RECIPES > 1) ? $clog2(NUM_RECIPES) : 1;
    localparam int TW  = $clog2(TICKS_PER_SEC + 1);
    localparam int BW  = $clog2(BEEP_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

    logic [11:0]            t_q, t_prev;
    logic                   conf_q, conf_prev, porta_q;
    logic [NUM_RECIPES-1:0] r_q, r_prev;
    logic [11:0]            t_edge;
    logic                   conf_edge;
    logic [NUM_RECIPES-1:0] r_edge;

    action_t                act;
    logic [3:0]             dig;
    logic [RW-1:0]          rec;

    state_t                 state, state_n;
    logic [TMW-1:0]         tm, tm_n, tm_wr, tm_dec;
    logic [CW-1:0]          cursor, cursor_n;
    logic [TW-1:0]          tick, tick_n;
    logic [BW-1:0]          beep, beep_n;
    logic [RW-1:0]          sel, sel_n;
    logic                   slot_we, can_write, borrow;
    logic [TMW-1:0]         slot [NUM_RECIPES];
    logic [7*DIGITS-1:0]    seg_w;

    assign t_edge    = t_q & ~t_prev;
    assign conf_edge = conf_q & ~conf_prev;
    assign r_edge    = r_q & ~r_prev;
    assign can_write = (cursor < CW'(DIGITS));

    // Register the panel inputs so edges are detected one cycle after a level rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= '0; t_prev <= '0; conf_q <= 1'b0; conf_prev <= 1'b0;
            r_q <= '0; r_prev <= '0; porta_q <= 1'b0;
        end else begin
            t_q <= t; t_prev <= t_q; conf_q <= conf; conf_prev <= conf_q;
            r_q <= r; r_prev <= r_q; porta_q <= porta;
        end
    end

    // Resolve simultaneous edges into a single action; lowest index wins within a group.
    always_comb begin
        act = ACT_NONE;
        dig = '0;
        rec = '0;
        for (int i = NUM_RECIPES - 1; i >= 0; i--)
            if (r_edge[i]) rec = RW'(i);
        for (int i = 9; i >= 0; i--)
            if (t_edge[i]) dig = 4'(i);
        if (t_edge[KEY_CANCEL])    act = ACT_CANCEL;
        else if (t_edge[KEY_START]) act = ACT_START;
        else if (conf_edge)         act = ACT_CONF;
        else if (|r_edge)           act = ACT_RECIPE;
        else if (|t_edge[9:0])      act = ACT_DIGIT;
    end

    // Time with the pressed digit written at the cursor position (d0 fills first).
    always_comb begin
        tm_wr = tm;
        for (int i = 0; i < DIGITS; i++)
            if (cursor == CW'(i)) tm_wr[4*i +: 4] = dig;
    end

    // One-second decrement: seconds count down as BCD; 00 seconds wraps to 59 and borrows minutes.
    always_comb begin
        tm_dec = tm;
        borrow = 1'b1;
        if (tm[7:0] != 8'h00) begin
            tm_dec[3:0] = bcd_dec(tm[3:0]);
            if (tm[3:0] == 4'd0) tm_dec[7:4] = bcd_dec(tm[7:4]);
        end else begin
            tm_dec[7:0] = 8'h59;
            for (int i = 2; i < DIGITS; i++) begin
                if (borrow) begin
                    tm_dec[4*i +: 4] = bcd_dec(tm[4*i +: 4]);
                    borrow = (tm[4*i +: 4] == 4'd0);
                end
            end
        end
    end

    // Next-state and datapath updates for the controller FSM.
    always_comb begin
        state_n  = state;
        tm_n     = tm;
        cursor_n = cursor;
        tick_n   = tick;
        beep_n   = beep;
        sel_n    = sel;
        slot_we  = 1'b0;
        case (state)
            IDLE: begin
                case (act)
                    ACT_DIGIT:  begin tm_n = TMW'(dig); cursor_n = CW'(1); state_n = ENTRY; end
                    ACT_RECIPE: begin tm_n = slot[rec]; cursor_n = CW'(DIGITS); state_n = ENTRY; end
                    ACT_CONF:   state_n = CONF_SEL;
                    default: ;
                endcase
            end
            ENTRY: begin
                case (act)
                    ACT_CANCEL: begin tm_n = '0; cursor_n = '0; state_n = IDLE; end
                    ACT_START: begin
                        if (!porta_q && tm != '0) begin
                            tick_n  = '0;
                            state_n = COOK;
                        end
                    end
                    ACT_RECIPE: begin tm_n = slot[rec]; cursor_n = CW'(DIGITS); end
                    ACT_DIGIT: begin
                        if (can_write) begin tm_n = tm_wr; cursor_n = cursor + CW'(1); end
                    end
                    default: ;
                endcase
            end
            COOK: begin
                if (act == ACT_CANCEL || porta_q) begin
                    state_n = PAUSED;
                end else if (tick == TICK_LAST) begin
                    tick_n = '0;
                    tm_n   = tm_dec;
                    if (tm_dec == '0) begin beep_n = '0; state_n = DONE; end
                end else begin
                    tick_n = tick + TW'(1);
                end
            end
            PAUSED: begin
                if (act == ACT_CANCEL) begin
                    tm_n = '0; cursor_n = '0; state_n = IDLE;
                end else if (act == ACT_START && !porta_q) begin
                    state_n = COOK;
                end
            end
            DONE: begin
                if (act == ACT_CANCEL || beep == BEEP_LAST) state_n = IDLE;
                else beep_n = beep + BW'(1);
            end
            CONF_SEL: begin
                if (act == ACT_RECIPE) begin
                    sel_n = rec; tm_n = '0; cursor_n = '0; state_n = CONF_REC;
                end else if (act != ACT_NONE) begin
                    state_n = IDLE;
                end
            end
            CONF_REC: begin
                if (act == ACT_CANCEL) begin
                    tm_n = '0; cursor_n = '0; state_n = IDLE;
                end else if (!can_write) begin
                    slot_we = 1'b1; state_n = IDLE;
                end else if (act == ACT_DIGIT) begin
                    tm_n = tm_wr; cursor_n = cursor + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, time, counters and recipe slot storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE; tm <= '0; cursor <= '0; tick <= '0; beep <= '0; sel <= '0;
            for (int i = 0; i < NUM_RECIPES; i++) slot[i] <= '0;
        end else begin
            state <= state_n; tm <= tm_n; cursor <= cursor_n;
            tick <= tick_n; beep <= beep_n; sel <= sel_n;
            if (slot_we) slot[sel] <= tm;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_dec u_dec (.bcd(tm[4*g +: 4]), .seg(seg_w[7*g +: 7]));
    end

    // Registered display and actuator outputs, one cycle behind the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= {DIGITS{SEG7_0}}; luz <= porta; motor <= 1'b0; aquec <= 1'b0; som <= 1'b0;
        end else begin
            seg   <= seg_w;
            luz   <= (state == COOK) || porta;
            motor <= (state == COOK);
            aquec <= (state == COOK);
            som   <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_microwave_ctrl_param.sv
// tb/tb_microwave_ctrl_param.sv - self-checking bench for microwave_ctrl_param
`timescale 1ns/1ps
module tb_microwave_ctrl_param;

    localparam int DIGITS = 4;
    localparam int NREC   = 4;
    localparam int TPS    = 10;
    localparam int BEEP   = 20;

    logic            clk = 1'b0;
    logic            rst, conf, porta;
    logic [11:0]     t;
    logic [NREC-1:0] r;
    logic [27:0]     seg;
    logic            luz, motor, aquec, som;

    always #5 clk = ~clk;

    microwave_ctrl_param #(
        .DIGITS(DIGITS), .NUM_RECIPES(NREC), .TICKS_PER_SEC(TPS), .BEEP_CYCLES(BEEP)
    ) dut (
        .clk(clk), .rst(rst), .t(t), .conf(conf), .r(r), .porta(porta),
        .seg(seg), .luz(luz), .motor(motor), .aquec(aquec), .som(som)
    );

    int vectors = 0;
    int miscompares = 0;

    longint aq_fall_t = -1, som_rise_t = -1, som_fall_t = -1;
    logic   aq_prev = 1'b0, som_prev = 1'b0;

    always @(negedge clk) begin
        if (!aquec && aq_prev) aq_fall_t = $time;
        if (som && !som_prev)  som_rise_t = $time;
        if (!som && som_prev)  som_fall_t = $time;
        aq_prev  = aquec;
        som_prev = som;
    end

    typedef struct {
        string       name;
        int          nk;
        logic [19:0] keys;
        int          cook_w;
        logic [15:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string n, int nk, logic [19:0] k, int w, logic [15:0] e);
        vec_t v;
        v.name = n; v.nk = nk; v.keys = k; v.cook_w = w; v.exp = e;
        return v;
    endfunction

    function automatic logic [6:0] pat(int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [27:0] disp(int mins, int secs);
        return {pat(mins / 10), pat(mins % 10), pat(secs / 10), pat(secs % 10)};
    endfunction

    function automatic logic [27:0] bcd_disp(logic [15:0] b);
        return disp(int'(b[15:12]) * 10 + int'(b[11:8]), int'(b[7:4]) * 10 + int'(b[3:0]));
    endfunction

    // Reference countdown on plain minute/second integers.
    function automatic logic [27:0] model_after(int mins, int secs, int ndec);
        for (int i = 0; i < ndec; i++) begin
            if (secs > 0) secs--;
            else begin secs = 59; mins--; end
        end
        return disp(mins, secs);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int idx);
        t[idx] = 1'b1; @(negedge clk);
        t[idx] = 1'b0; @(negedge clk);
    endtask

    task automatic pulse_r(input int idx);
        r[idx] = 1'b1; @(negedge clk);
        r[idx] = 1'b0; @(negedge clk);
    endtask

    task automatic enter(input int n, input logic [19:0] k);
        for (int i = 0; i < n; i++) pulse(int'(k[4*i +: 4]));
    endtask

    // Start, let it run w cycles from the start press, then cancel into PAUSED.
    task automatic cook_for(input int w);
        pulse(10);
        step(w - 2);
        pulse(11);
        step(3);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && som_fall_t < 0; i++) @(negedge clk);
        check("done_reached", 32'(som_fall_t >= 0), 32'd1);
    endtask

    int      mins, secs, w, tot;
    int      d[4];
    longint  t0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        t = '0; conf = 1'b0; r = '0; porta = 1'b1; rst = 1'b1;
        step(3);
        check("rst_seg", seg, bcd_disp(16'h0000));
        check("rst_luz_door", luz, 1'b1);
        check("rst_act", {motor, aquec, som}, 3'b000);
        porta = 1'b0; rst = 1'b0;
        step(3);
        check("idle_luz_closed", luz, 1'b0);

        vq.push_back(mk("entry_521",       3, 20'h00125,   0, 16'h0125));
        vq.push_back(mk("entry_full",      5, 20'h54321,   0, 16'h4321));
        vq.push_back(mk("entry_one",       1, 20'h00009,   0, 16'h0009));
        vq.push_back(mk("cook_1476_30s",   4, 20'h01476, 301, 16'h1446));
        vq.push_back(mk("cook_0100_wrap",  3, 20'h00100,  11, 16'h0059));
        vq.push_back(mk("cook_0075",       2, 20'h00075,  11, 16'h0074));
        vq.push_back(mk("cook_0100_hold",  3, 20'h00100,  10, 16'h0100));

        foreach (vq[i]) begin
            enter(vq[i].nk, vq[i].keys);
            step(2);
            if (vq[i].cook_w > 0) cook_for(vq[i].cook_w);
            check(vq[i].name, seg, bcd_disp(vq[i].exp));
            check("vec_aquec_off", aquec, 1'b0);
            pulse(11);
            step(3);
            check("vec_cancel_clear", seg, bcd_disp(16'h0000));
        end

        for (int it = 0; it < 5; it++) begin
            d[0] = $urandom_range(0, 9); d[1] = $urandom_range(0, 9);
            d[2] = $urandom_range(1, 9); d[3] = $urandom_range(0, 9);
            mins = d[3] * 10 + d[2];
            secs = d[1] * 10 + d[0];
            enter(4, {4'h0, 4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])});
            step(2);
            check("rand_entry", seg, disp(mins, secs));
            tot = 0;
            for (int s = 0; s < 2; s++) begin
                w = $urandom_range(2, 250);
                cook_for(w);
                tot += w - 1;
                check("rand_paused_time", seg, model_after(mins, secs, tot / TPS));
                check("rand_paused_act", {aquec, motor, luz}, 3'b000);
            end
            pulse(11);
            step(3);
            check("rand_idle_clear", seg, bcd_disp(16'h0000));
        end

        enter(3, 20'h00125);
        step(2);
        som_rise_t = -1; som_fall_t = -1; aq_fall_t = -1;
        t0 = $time;
        pulse(10);
        wait_done(1000);
        check("cook_85s_len", 32'(som_rise_t - t0), 32'((85 * TPS + 3) * 10));
        check("beep_len", 32'(som_fall_t - som_rise_t), 32'(BEEP * 10));
        check("aquec_fall_at_som_rise", 32'(aq_fall_t), 32'(som_rise_t));
        check("done_seg", seg, bcd_disp(16'h0000));
        step(3);

        enter(1, 20'h00005);
        step(2);
        pulse(10);
        step(18);
        porta = 1'b1;
        step(4);
        check("door_pause_luz_aquec", {luz, aquec}, 2'b10);
        check("door_pause_time", seg, bcd_disp(16'h0004));
        pulse(10);
        step(4);
        check("start_door_open", aquec, 1'b0);
        porta = 1'b0;
        step(7);
        som_rise_t = -1; som_fall_t = -1;
        t0 = $time;
        pulse(10);
        wait_done(200);
        check("resume_len", 32'(som_rise_t - t0), 32'((5 * TPS - 19 + 3) * 10));
        step(3);

        conf = 1'b1; step(1); conf = 1'b0; step(1);
        pulse_r(2);
        enter(4, 20'h00349);
        step(3);
        check("conf_rec_show", seg, bcd_disp(16'h0349));
        enter(1, 20'h00007);
        step(2);
        check("idle_digit_clears", seg, bcd_disp(16'h0007));
        pulse(11);
        step(3);
        pulse_r(2);
        step(2);
        check("recall_slot2", seg, bcd_disp(16'h0349));
        cook_for(51);
        check("recall_cook", seg, model_after(3, 49, 5));
        pulse(11);
        step(3);
        pulse_r(1);
        step(2);
        check("recall_slot1", seg, bcd_disp(16'h0000));
        pulse(10);
        step(5);
        check("start_zero_ignored", aquec, 1'b0);
        pulse(11);
        step(3);

        enter(1, 20'h00003);
        step(2);
        t[10] = 1'b1; t[11] = 1'b1; @(negedge clk);
        t[10] = 1'b0; t[11] = 1'b0;
        step(4);
        check("cancel_beats_start_seg", seg, bcd_disp(16'h0000));
        check("cancel_beats_start_aquec", aquec, 1'b0);

        enter(2, 20'h00012);
        step(2);
        pulse(10);
        step(30);
        check("cook_running", {aquec, motor, luz}, 3'b111);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_seg", seg, bcd_disp(16'h0000));
        check("rst_mid_outs", {luz, motor, aquec, som}, 4'b0000);
        rst = 1'b0;
        step(2);
        pulse_r(2);
        step(2);
        check("slot2_cleared", seg, bcd_disp(16'h0000));
        pulse(10);
        step(5);
        check("slot2_cleared_nostart", aquec, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
